// File: rtl/dm_resp.sv
// Data-memory responder: one outstanding word load/store, LAT wait states, then a
// response held until the requester accepts it.
module dm_resp #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          enter_resp;
  logic          acc_wr;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  assign accept     = (state_q == StIdle) && req_valid;
  assign enter_resp = (accept && (LAT == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  always_comb begin
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == StIdle) begin
      acc_wr    = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH);
  assign acc_idx = acc_addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d   = 4'(LAT);
          state_d = (LAT == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (enter_resp && acc_wr && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= acc_err;
      rdata_q <= (!acc_wr && !acc_err) ? mem_q[acc_idx] : 32'd0;
    end else if ((state_q == StResp) && resp_ready) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/dm_resp.md
# dm_resp

Data-memory responder for the five-stage CPU: the slave end of the load/store path. Accepts one word read or write request at a time over a valid/ready handshake, holds it for a programmable number of wait states, then returns a response (read data plus error flag) that stays valid until the CPU side accepts it. It replaces the fixed single-cycle data memory so the pipeline can be exercised against a memory with real latency and back-pressure.

## Interface

- DEPTH, 128, number of 32-bit words of storage.
- AW, 7, word-index width; DEPTH <= 2**AW.
- LAT, 2, wait cycles inserted between request acceptance and response; 0..15 legal.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; word index = req_addr[AW+1:2]
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores, bit i covers bits 8i+7:8i; ignored for loads
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  32  load data (0 for stores and errors)
- resp_err  out  1  request was misaligned or out of range
- busy  out  1  high whenever state is not IDLE

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready at an edge: capture write, addr, wdata, be; load wait counter with LAT; go to WAIT if LAT > 0, else RESP.
- WAIT: req_ready = 0; counter decrements each cycle; when counter reaches 1 it transitions to RESP at the next edge (exactly LAT cycles spent in WAIT).
- Entering RESP (same edge): error check, memory access, response registers loaded.
  - err = (addr[1:0] != 0) | (addr[31:2] >= DEPTH).
  - Store, no err: bytes with be=1 updated, others unchanged; resp_rdata = 0.
  - Load, no err: resp_rdata = stored word.
  - err: no memory update, resp_rdata = 0, resp_err = 1.
- RESP: resp_valid = 1; resp_rdata/resp_err held stable until resp_valid & resp_ready at an edge, then go to IDLE and clear resp_valid, resp_rdata, resp_err.
- Only one request outstanding; req_ready never high while busy.
- Store with be = 0000 is a legal no-op; it returns resp_err = 0.
- Request inputs are sampled only at the accept edge; changes afterwards have no effect.

## Timing

- Reset (async assert): state IDLE, req_ready = 1 after reset, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, counter = 0, all DEPTH words = 0.
- Reset mid-transaction: the transaction is aborted. A store whose RESP edge has not occurred is never committed. Storage is zeroed regardless.
- Accept at edge T: resp_valid first high in the cycle after edge T+LAT (LAT=0: the cycle after T).
- Response handshake at edge R: req_ready high in the cycle after R. The earliest next accept is edge R+1.
- Minimum issue interval is LAT+2 cycles with resp_ready tied high.
- resp_ready low stalls indefinitely in RESP with outputs constant.
- resp_ready high during IDLE/WAIT is ignored.
- A load following a store to the same address returns the stored data, because the store commits before req_ready returns.

## Test plan

- Reset then LAT=2. Store addr 0x10, wdata 0xDEADBEEF, be 1111, resp_ready=1. Expected: resp_valid high in the cycle after accept edge+2, resp_err=0. Then load 0x10. Expected: resp_rdata=0xDEADBEEF.
- Partial store. be=0101, wdata 0x11223344 to addr 0x10 (holding 0xDEADBEEF). Then load. Expected: 0xDE22BE44.
- Errors. Load 0x12. Expected: resp_err=1, rdata 0. Store 0x200 with DEPTH=128. Expected: resp_err=1. A later load of 0x0 returns 0, so nothing was written.
- Back-pressure. Hold resp_ready=0 for 5 cycles after resp_valid. Expected: resp_valid/rdata stable, req_ready=0, busy=1. Raise resp_ready. Expected: req_ready high in the next cycle.
- LAT=0 back-to-back. Issue loads with req_valid held high and resp_ready=1. Expected: accepts every 2 cycles, resp_valid 1 cycle after each accept.
- Assert rst while in WAIT of store 0x55555555 to 0x4. Expected: outputs return to reset values immediately. A subsequent load of 0x4 returns 0.
